disp_scan: RTL

Time-multiplexed 8-digit seven-segment scanner that consumes the eight 4-bit digit values produced by the hex-splitting stage and drives the board's common-anode display. It snapshots all digits at the start of every scan frame, so the shown value never tears. It then cycles one digit at a time at a programmable rate, decoding hex to active-low segments. It supports per-digit blanking, decimal points and optional leading-zero suppression.

---
 rtl/disp_pkg.sv | 14 +
 rtl/disp_scan_if.sv | 22 ++
 rtl/hex_to_seg.sv | 9 +
 rtl/disp_scan.sv | 103 ++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared display constants: digit count, active-low segment patterns and "all off" codes.
package disp_pkg;
  localparam int DIGITS = 8;
  localparam int IDX_W  = $clog2(DIGITS);

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} for hex 0..F
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/disp_scan_if.sv
// Digit source to scanner link: eight hex digits plus per-digit controls in, display drive out.
interface disp_scan_if;
  import disp_pkg::*;

  logic [3:0]        Hex0, Hex1, Hex2, Hex3, Hex4, Hex5, Hex6, Hex7;
  logic [DIGITS-1:0] point;
  logic [DIGITS-1:0] LES;
  logic              lzs;
  logic [7:0]        AN;
  logic [7:0]        SEGMENT;
  logic              frame_start;

  modport master (
    output Hex0, Hex1, Hex2, Hex3, Hex4, Hex5, Hex6, Hex7, point, LES, lzs,
    input  AN, SEGMENT, frame_start
  );

  modport slave (
    input  Hex0, Hex1, Hex2, Hex3, Hex4, Hex5, Hex6, Hex7, point, LES, lzs,
    output AN, SEGMENT, frame_start
  );
endinterface

// File: rtl/hex_to_seg.sv
// Combinational hex to active-low seven-segment decoder, shared by display consumers.
module hex_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[hex];
endmodule

// File: rtl/disp_scan.sv
// Eight-digit multiplexed seven-segment scanner with per-frame snapshot, blanking,
// decimal points and leading-zero suppression.
module disp_scan
  import disp_pkg::*;
#(
  parameter int TICK_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  disp_scan_if.slave bus
);
  localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);

  // Digit i is suppressed when it and every digit to its left are zero; digit 0 always shows.
  function automatic logic [DIGITS-1:0] lz_dark(input logic [DIGITS-1:0][3:0] hex,
                                                input logic en);
    logic zero_above;
    lz_dark    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (hex[i] == 4'd0);
      lz_dark[i] = en && zero_above;
    end
  endfunction

  logic [DIGITS-1:0][3:0] live_hex;
  logic [CW-1:0]          cnt;
  logic [IDX_W-1:0]       idx;
  logic                   tick;
  logic                   wrap;

  logic [DIGITS-1:0][3:0] snap_hex;
  logic [DIGITS-1:0]      snap_point;
  logic [DIGITS-1:0]      snap_les;
  logic                   snap_lzs;
  logic                   snap_vld_p0;

  logic [DIGITS-1:0]      lz;
  logic                   dark;
  logic [6:0]             seg_dec;
  logic [7:0]             an_p1;
  logic [7:0]             seg_p1;
  logic                   frame_start_p1;

  assign live_hex = {bus.Hex7, bus.Hex6, bus.Hex5, bus.Hex4,
                     bus.Hex3, bus.Hex2, bus.Hex1, bus.Hex0};
  assign tick     = (cnt == TICK_MAX);
  assign wrap     = tick && (idx == IDX_W'(DIGITS - 1));

  // Stage p0: prescaler, digit index and frame snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      snap_hex    <= '0;
      snap_point  <= '0;
      snap_les    <= '0;
      snap_lzs    <= 1'b0;
      snap_vld_p0 <= 1'b0;
    end else begin
      cnt         <= tick ? '0 : cnt + 1'b1;
      snap_vld_p0 <= wrap;
      if (tick) idx <= idx + 1'b1;
      if (wrap) begin
        snap_hex   <= live_hex;
        snap_point <= bus.point;
        snap_les   <= bus.LES;
        snap_lzs   <= bus.lzs;
      end
    end
  end

  assign lz   = lz_dark(snap_hex, snap_lzs);
  assign dark = snap_les[idx] || lz[idx];

  hex_to_seg u_dec (
    .hex (snap_hex[idx]),
    .seg (seg_dec)
  );

  // Stage p1: registered anode/segment drive, both updated on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p1          <= AN_OFF;
      seg_p1         <= SEG_OFF;
      frame_start_p1 <= 1'b0;
    end else begin
      frame_start_p1 <= snap_vld_p0;
      if (dark) begin
        an_p1  <= AN_OFF;
        seg_p1 <= SEG_OFF;
      end else begin
        an_p1  <= ~(8'b1 << idx);
        seg_p1 <= {~snap_point[idx], seg_dec};
      end
    end
  end

  assign bus.AN          = an_p1;
  assign bus.SEGMENT     = seg_p1;
  assign bus.frame_start = frame_start_p1;
endmodule
